// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - register file / scoreboard access bundle
// Purpose: groups the write, reserve and dual-read signals of regfile_scoreboard.
// Parameters: k = data width, n = address width (depth 2**n).
// Modports:
//   master - controller side: drives data_in, writenum, write, reservenum, reserve,
//            readnum_a, readnum_b; receives data_out_a/b, busy_a/b, busy_vec, busy_count.
//   slave  - register file side: the mirror image of master.
interface regfile_scoreboard_if #(
  parameter int k = 16,
  parameter int n = 3
);
  logic [k-1:0]        data_in;
  logic [n-1:0]        writenum;
  logic                write;
  logic [n-1:0]        reservenum;
  logic                reserve;
  logic [n-1:0]        readnum_a;
  logic [n-1:0]        readnum_b;
  logic [k-1:0]        data_out_a;
  logic [k-1:0]        data_out_b;
  logic                busy_a;
  logic                busy_b;
  logic [(1<<n)-1:0]   busy_vec;
  logic [n:0]          busy_count;

  modport master (
    output data_in, writenum, write, reservenum, reserve, readnum_a, readnum_b,
    input  data_out_a, data_out_b, busy_a, busy_b, busy_vec, busy_count
  );

  modport slave (
    input  data_in, writenum, write, reservenum, reserve, readnum_a, readnum_b,
    output data_out_a, data_out_b, busy_a, busy_b, busy_vec, busy_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 2-read/1-write register file with busy scoreboard
// Purpose: 2**n x k register file with two combinational read ports and a
//   per-entry busy bit set by reserve and cleared by write (reserve wins on
//   the same index), plus a registered count of busy entries.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears entries, busy bits and count
//   bus   - regfile_scoreboard_if.slave (write, reserve, read A/B, busy status)
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through forwarding onto
//   read ports whose address matches writenum.
module regfile_scoreboard #(
  parameter int k = 16,
  parameter int n = 3
) (
  input logic                  clk,
  input logic                  reset,
  regfile_scoreboard_if.slave  bus
);
  localparam int DEPTH = 1 << n;

  logic [k-1:0]     mem_q [DEPTH];
  logic [k-1:0]     mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [n:0]       count_q, count_d;
  logic             inc, dec;

  always_comb begin
    mem_d   = mem_q;
    busy_d  = busy_q;
    if (bus.write) begin
      mem_d[bus.writenum]  = bus.data_in;
      busy_d[bus.writenum] = 1'b0;
    end
    // Applied after the write so a same-index reserve leaves the entry busy.
    if (bus.reserve) begin
      busy_d[bus.reservenum] = 1'b1;
    end
    // Count changes only on real 0->1 or 1->0 transitions of a busy bit,
    // which keeps it equal to popcount(busy) without a population counter.
    inc = bus.reserve && !busy_q[bus.reservenum];
    dec = bus.write && busy_q[bus.writenum] &&
          !(bus.reserve && (bus.reservenum == bus.writenum));
    count_d = count_q + {{n{1'b0}}, inc} - {{n{1'b0}}, dec};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign bus.busy_vec   = busy_q;
  assign bus.busy_count = count_q;

`ifdef REGFILE_BYPASS_EN
  logic fwd_a, fwd_b;
  assign fwd_a = bus.write && !reset && (bus.writenum == bus.readnum_a);
  assign fwd_b = bus.write && !reset && (bus.writenum == bus.readnum_b);

  assign bus.data_out_a = fwd_a ? bus.data_in : mem_q[bus.readnum_a];
  assign bus.data_out_b = fwd_b ? bus.data_in : mem_q[bus.readnum_b];
  assign bus.busy_a     = fwd_a ? 1'b0 : busy_q[bus.readnum_a];
  assign bus.busy_b     = fwd_b ? 1'b0 : busy_q[bus.readnum_b];
`else
  assign bus.data_out_a = mem_q[bus.readnum_a];
  assign bus.data_out_b = mem_q[bus.readnum_b];
  assign bus.busy_a     = busy_q[bus.readnum_a];
  assign bus.busy_b     = busy_q[bus.readnum_b];
`endif
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised 2-read/1-write register file with a per-register busy scoreboard.
- Generalises the 8x16 single-port register file to 2**n entries of k bits, with two independent read ports.
- Adds synchronous clear and reservation tracking, so a datapath controller can stall on operands whose producing write is still in flight.
- Sits between the instruction decoder/controller and the ALU operand latches.

Parameters:
k, 16, data width in bits
n, 3, address width; depth = 2**n entries

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
data_in  input  k  write data
writenum  input  n  write address
write  input  1  write enable
reservenum  input  n  address to mark busy
reserve  input  1  reservation enable
readnum_a  input  n  read port A address
readnum_b  input  n  read port B address
data_out_a  output  k  read port A data
data_out_b  output  k  read port B data
busy_a  output  1  busy bit of entry readnum_a
busy_b  output  1  busy bit of entry readnum_b
busy_vec  output  2**n  all busy bits, bit i = entry i
busy_count  output  n+1  number of set busy bits

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high, named reset.
- Reset: at a posedge clk with reset=1, all entries go to 0, busy_vec to 0 and busy_count to 0. Reset overrides write and reserve in that cycle.
- Write: at a posedge with write=1 and reset=0:
  - entry[writenum] <= data_in;
  - busy[writenum] <= 0.
  - Writing a non-busy entry is legal; it updates data and leaves busy at 0.
- Reserve: at a posedge with reserve=1 and reset=0, busy[reservenum] <= 1. Reserving an already-busy entry is legal and leaves it busy.
- Write and reserve to the same index in the same cycle: data is written and busy ends at 1 (reserve wins).
- Write and reserve to different indices: both take effect.
- Reads are combinational, with 0-cycle latency from the address:
  - data_out_x = entry[readnum_x];
  - busy_x = busy[readnum_x].
  - Both ports may address the same entry.
- Without bypass, reads return state as of the last clock edge; a write becomes visible the cycle after it is issued.
- busy_count is a register, updated each edge by:
  - +1 if reserve sets a bit that was 0;
  - -1 if write clears a bit that was 1 and reserve does not re-set it in the same cycle.
  - busy_count must equal popcount(busy_vec) at all times; it ranges 0..2**n with no wrap.
- busy_vec and busy_count are registered outputs; busy_a and busy_b are combinational from them.
- No X propagation: every output is defined from the first edge after reset. Before the first reset, contents are undefined.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: when write=1, reset=0 and writenum==readnum_x:
  - data_out_x = data_in;
  - busy_x = 0 (write-through forwarding, same cycle).
  - Applies independently to ports A and B.
  - busy_vec and busy_count are unaffected; they still update only at the edge.
- Undefined: no forwarding; read ports see only stored state, as described above.

Test Plan:
1. Reset then read → reset=1 for one edge, then readnum_a=0, readnum_b=7 → data_out_a=0, data_out_b=0, busy_vec=8'h00, busy_count=0.
2. Write/read-back → write 16'hBEEF to entry 3; next cycle readnum_a=3, readnum_b=3 → both outputs 16'hBEEF. With REGFILE_BYPASS_EN, the same-cycle read also returns 16'hBEEF.
3. Scoreboard → reserve entries 2 and 5 on consecutive edges → busy_vec=8'h24, busy_count=2, busy_a=1 for readnum_a=5. Then write entry 5 with 16'h0042 → busy_vec=8'h04, busy_count=1, data_out_a=16'h0042.
4. Simultaneous write+reserve, same index → entry 6 not busy; write=1, reserve=1, both index 6, data 16'h1234 → after the edge entry 6=16'h1234, busy[6]=1, busy_count incremented by 1.
5. Double reserve and full → reserve entry 1 twice, then reserve all 8 entries → busy_count=1 after the double reserve, 8 after all, never 9. Then write all 8 entries → busy_count returns to 0.
6. Reset mid-operation → entries 0..7 hold nonzero data and 4 entries are busy; assert reset together with write=1 and reserve=1 → after the edge all entries 0, busy_vec=0, busy_count=0.
